// File: rtl/qspi_sram_responder.sv
// qspi_sram_responder: quad-SPI SRAM target (0xEB read, 0x38 write) over a byte memory port.
// Optional QSPI_RESP_SPI_READ_EN adds 0x03 single-bit read on sio[1].
// Ports: clk_i/rst_ni; sck, cs_n, sio_in/sio_out/sio_oe pins (synchronous to clk_i);
//        mem_addr/mem_we/mem_wdata/mem_re/mem_rdata memory port (rdata one cycle after re); busy.
module qspi_sram_responder #(
  parameter int          MEM_AW       = 10,
  parameter int          DUMMY_CYCLES = 6,
  parameter logic [7:0]  READ_CMD     = 8'hEB,
  parameter logic [7:0]  WRITE_CMD    = 8'h38
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sck,
  input  logic              cs_n,
  input  logic [3:0]        sio_in,
  output logic [3:0]        sio_out,
  output logic [3:0]        sio_oe,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  typedef enum logic [3:0] {
    IDLE, CMD, ADDR, DUMMY, RDATA,
    WDATA, IGNORE, SADDR, SDATA
  } state_t;

  state_t            state;
  logic              sck_q;
  logic [4:0]        cnt;
  logic [6:0]        cmd_sh;
  logic [MEM_AW-1:0] addr_cnt;
  logic [MEM_AW-1:0] addr_nx;
  logic [7:0]        tx;
  logic [3:0]        wr_hi;
  logic              rd_pend;
  logic              nib;
  logic              rise;
  logic              fall;
  logic [7:0]        op;
  logic [3:0]        hi_nib;

  assign rise    = sck & ~sck_q;
  assign fall    = ~sck & sck_q;
  assign op      = {cmd_sh, sio_in[0]};
  assign addr_nx = addr_cnt + MEM_AW'(1);
  // Read data arriving this very cycle bypasses tx so a fast sck
  // can still drive the next high nibble on time.
  assign hi_nib  = rd_pend ? mem_rdata[7:4] : tx[7:4];

`ifdef QSPI_RESP_SPI_READ_EN
  logic spi_bit;
  always_comb begin
    spi_bit = tx[cnt[2:0]];
    if (cnt[2:0] == 3'd7 && rd_pend)
      spi_bit = mem_rdata[7];
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      sck_q     <= 1'b0;
      cnt       <= '0;
      cmd_sh    <= '0;
      addr_cnt  <= '0;
      tx        <= '0;
      wr_hi     <= '0;
      rd_pend   <= 1'b0;
      nib       <= 1'b0;
      sio_out   <= '0;
      sio_oe    <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sck_q   <= sck;
      mem_we  <= 1'b0;
      mem_re  <= 1'b0;
      rd_pend <= mem_re;
      if (rd_pend)
        tx <= mem_rdata;
      if (cs_n) begin
        state   <= IDLE;
        sio_oe  <= '0;
        sio_out <= '0;
        cnt     <= '0;
        nib     <= 1'b0;
        busy    <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            state <= CMD;
            busy  <= 1'b1;
            cnt   <= '0;
            nib   <= 1'b0;
          end
          CMD: if (rise) begin
            cmd_sh <= op[6:0];
            cnt    <= cnt + 5'd1;
            if (cnt == 5'd7) begin
              cnt <= '0;
              unique case (1'b1)
                op == READ_CMD: begin
                  state <= ADDR;
                  nib   <= 1'b1;
                end
                op == WRITE_CMD: begin
                  state <= ADDR;
                  nib   <= 1'b0;
                end
`ifdef QSPI_RESP_SPI_READ_EN
                op == 8'h03: state <= SADDR;
`endif
                default: state <= IGNORE;
              endcase
            end
          end
          // nib doubles as the read/write flag while in ADDR
          ADDR: if (rise) begin
            addr_cnt <= {addr_cnt[MEM_AW-5:0], sio_in};
            cnt      <= cnt + 5'd1;
            if (cnt == 5'd5) begin
              cnt <= '0;
              nib <= 1'b0;
              if (nib) begin
                state    <= DUMMY;
                mem_re   <= 1'b1;
                mem_addr <= {addr_cnt[MEM_AW-5:0], sio_in};
              end else begin
                state <= WDATA;
              end
            end
          end
          // nib set means the dummy rises are done
          DUMMY: begin
            if (rise && !nib) begin
              cnt <= cnt + 5'd1;
              if (cnt == 5'(DUMMY_CYCLES - 1))
                nib <= 1'b1;
            end
            if (fall && nib) begin
              sio_oe  <= 4'b1111;
              sio_out <= hi_nib;
              nib     <= 1'b0;
              cnt     <= '0;
              state   <= RDATA;
            end
          end
          RDATA: if (fall) begin
            if (!nib) begin
              sio_out  <= tx[3:0];
              addr_cnt <= addr_nx;
              mem_addr <= addr_nx;
              mem_re   <= 1'b1;
              nib      <= 1'b1;
            end else begin
              sio_out <= hi_nib;
              nib     <= 1'b0;
            end
          end
          WDATA: if (rise) begin
            if (!nib) begin
              wr_hi <= sio_in;
              nib   <= 1'b1;
            end else begin
              mem_wdata <= {wr_hi, sio_in};
              mem_addr  <= addr_cnt;
              mem_we    <= 1'b1;
              addr_cnt  <= addr_nx;
              nib       <= 1'b0;
            end
          end
`ifdef QSPI_RESP_SPI_READ_EN
          SADDR: if (rise) begin
            addr_cnt <= {addr_cnt[MEM_AW-2:0], sio_in[0]};
            cnt      <= cnt + 5'd1;
            if (cnt == 5'd23) begin
              cnt      <= 5'd7;
              mem_re   <= 1'b1;
              mem_addr <= {addr_cnt[MEM_AW-2:0], sio_in[0]};
              state    <= SDATA;
            end
          end
          SDATA: if (fall) begin
            sio_oe  <= 4'b0010;
            sio_out <= {2'b00, spi_bit, 1'b0};
            cnt     <= cnt - 5'd1;
            if (cnt[2:0] == 3'd0) begin
              cnt      <= 5'd7;
              addr_cnt <= addr_nx;
              mem_addr <= addr_nx;
              mem_re   <= 1'b1;
            end
          end
`endif
          IGNORE: ;
          default: state <= IGNORE;
        endcase
      end
    end
  end

endmodule

// File: doc/qspi_sram_responder.md
Name: qspi_sram_responder

Overview:
- Synthesizable QSPI SRAM target. It is the responder end of the quad-SPI link that our Wishbone-side SRAM controller drives.
- Decodes quad read (0xEB) and quad write (0x38) from the pins and services them against a simple synchronous byte memory port.
- Used for on-chip loopback tests and as an SRAM stand-in on the secondary CS. sck, cs_n and sio are synchronous to clk_i: the initiator runs on the same clock, so there are no synchronizers.

Parameters:
- MEM_AW, 10: memory address width. Only the low MEM_AW bits of the 24-bit SPI address are used; upper bits are ignored.
- DUMMY_CYCLES, 6: sck cycles between the last address nibble and the first read-data nibble.
- READ_CMD, 8'hEB: quad read opcode.
- WRITE_CMD, 8'h38: quad write opcode.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- sck  input  1  serial clock from initiator (period at least 2 clk_i)
- cs_n  input  1  chip select, active low
- sio_in  input  4  pin inputs; sio_in[0] is MOSI in single-bit phases
- sio_out  output  4  pin outputs
- sio_oe  output  4  pin output enables
- mem_addr  output  MEM_AW  memory byte address
- mem_we  output  1  write strobe, one clk_i pulse
- mem_wdata  output  8  write data
- mem_re  output  1  read strobe, one clk_i pulse
- mem_rdata  input  8  read data, valid exactly one clk_i after mem_re
- busy  output  1  high while cs_n low and a command is being serviced

Behaviour:
- Reset (async, rst_ni=0) drives these values: sio_out=0, sio_oe=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, busy=0, state=IDLE.
- Edge detect: register sck_q.
  - rise = sck & ~sck_q; fall = ~sck & sck_q.
  - Inputs are sampled only on the clk_i cycle where rise is true.
  - sio_out/sio_oe update on the clk_i edge following a detected fall.
- cs_n high in any state, sampled each clk_i: go to IDLE next cycle, sio_oe=0, bit/nibble counters cleared, any partially received write byte discarded. A mem_we already issued stands.
- IDLE: cs_n low -> CMD with bit counter 0. busy=1 from that cycle until return to IDLE.
- CMD: shift sio_in[0] MSB-first on 8 rises.
  - On the 8th rise, decode the opcode:
    - READ_CMD -> ADDR, read.
    - WRITE_CMD -> ADDR, write.
    - anything else -> IGNORE.
- IGNORE: sio_oe stays 0, no memory access, wait for cs_n high.
- ADDR: 6 rises, each shifts a 4-bit nibble into a 24-bit register, high nibble first.
  - After the 6th, load the address counter with addr[MEM_AW-1:0].
  - Read: go to DUMMY and pulse mem_re with mem_addr=address on the next clk_i.
  - Write: go to WDATA.
- DUMMY: count DUMMY_CYCLES rises; capture mem_rdata into the tx byte the cycle after mem_re.
  - On the fall following the last dummy rise: sio_oe=4'b1111, sio_out=tx[7:4], go to RDATA.
- RDATA: on each fall, drive the next nibble.
  - Even nibble: tx[3:0]. Also increment the address (wraps mod 2^MEM_AW) and pulse mem_re.
  - Odd nibble: the new tx[7:4].
  - This is an endless incrementing burst while cs_n stays low.
- WDATA: first rise latches the high nibble; second rise completes the byte.
  - On completion: mem_wdata=byte, mem_addr=address, pulse mem_we next clk_i, increment the address (wrapping).
  - Further nibble pairs write consecutive bytes.
- sio_oe is nonzero only in RDATA, or in the SPI_READ data phase when the optional feature is built.
- Simultaneous cs_n rise and sck edge: cs_n wins; no sample, no mem strobe.
- mem_we and mem_re are never high in the same cycle.

Optional Feature:
- Macro QSPI_RESP_SPI_READ_EN.
- When defined, opcode 0x03 is also decoded as a single-bit read:
  - 24 address bits are shifted serially on sio_in[0] MSB-first.
  - No dummy cycles.
  - Data is driven MSB-first on sio_out[1] with sio_oe=4'b0010, same burst and increment rules.
- When undefined, 0x03 goes to IGNORE.

Test Plan:
- Write 0x38, addr 0x000010, data 0xA5, then cs_n high -> exactly one mem_we with mem_addr=0x010, mem_wdata=0xA5; sio_oe stays 0 throughout.
- Preload mem[0x010]=0x5A and send 0xEB, addr 0x000010 -> mem_re at 0x010; after 6 dummy sck the nibbles 0x5 then 0xA appear on sio_out with sio_oe=4'b1111 during sampling rises.
- Preload mem[0x3FF]=0x11, mem[0x000]=0x22 and burst-read 2 bytes from 0x0003FF -> data 0x11, 0x22; mem_addr wraps to 0x000.
- Send opcode 0x9F, 8 nibbles, then cs_n high -> no mem strobes, sio_oe=0, busy back to 0 one cycle after cs_n high.
- Raise cs_n after one write nibble, then reassert rst_ni=0 mid-read -> no mem_we; on reset all outputs are 0 immediately, asynchronously.
- With QSPI_RESP_SPI_READ_EN and mem[0x020]=0xC3, send 0x03 addr 0x000020 -> bits 1,1,0,0,0,0,1,1 on sio_out[1]. Without the macro -> no response.
